// File: rtl/branch_pred_pkg.sv
// Shared definitions for the gshare branch predictor: index-mode encodings
// and the per-entry saturating counter helpers.
package branch_pred_pkg;

    localparam int MODE_GLOBAL = 0;
    localparam int MODE_GSHARE = 1;

    // Weakly-not-taken start value: just below the taken threshold.
    function automatic logic [3:0] cnt_init_value(input int cnt_width);
        return 4'((1 << (cnt_width - 1)) - 1);
    endfunction

    // One step of a cnt_width-bit saturating up/down counter.
    function automatic logic [3:0] cnt_saturate(input logic [3:0] cnt, input logic inc,
                                                input int cnt_width);
        int v;
        int vmax;
        v    = int'(cnt);
        vmax = (1 << cnt_width) - 1;
        if (inc) begin
            if (v < vmax) v = v + 1;
        end else begin
            if (v > 0) v = v - 1;
        end
        return 4'(v);
    endfunction

endpackage

// File: rtl/branch_prediction_gshare_if.sv
// Predict request/response and branch-resolve (renew) signals of the predictor.
interface branch_prediction_gshare_if #(
    parameter int GHR_WIDTH = 10,
    parameter int PC_WIDTH  = 32
);
    logic                 predict_valid;
    logic [PC_WIDTH-1:0]  predict_pc;
    logic                 predict_out_valid;
    logic                 predict_result;
    logic [GHR_WIDTH-1:0] predict_index;
    logic [GHR_WIDTH-1:0] predict_history;
    logic                 renew_valid;
    logic [GHR_WIDTH-1:0] renew_index;
    logic [GHR_WIDTH-1:0] renew_history;
    logic                 renew_predict;
    logic                 renew_result;
    logic [15:0]          mispredict_count;

    modport master (
        output predict_valid, predict_pc,
        output renew_valid, renew_index, renew_history, renew_predict, renew_result,
        input  predict_out_valid, predict_result, predict_index, predict_history,
        input  mispredict_count
    );

    modport slave (
        input  predict_valid, predict_pc,
        input  renew_valid, renew_index, renew_history, renew_predict, renew_result,
        output predict_out_valid, predict_result, predict_index, predict_history,
        output mispredict_count
    );
endinterface

// File: rtl/branch_pred_counter_table.sv
// Table of saturating counters: one combinational read port, one update port.
// The read returns the pre-update value, so a same-cycle read and write to one
// entry sees the old counter.
module branch_pred_counter_table
    import branch_pred_pkg::*;
#(
    parameter int IDX_WIDTH = 10,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_WIDTH-1:0] rd_index,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_index,
    input  logic                 wr_taken
);
    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
    logic [CNT_WIDTH-1:0] cnt_d [DEPTH];

    assign rd_cnt = cnt_q[rd_index];

    // Only the addressed entry moves; everything else holds.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_index] = CNT_WIDTH'(cnt_saturate(4'(cnt_q[wr_index]), wr_taken, CNT_WIDTH));
        end
    end

    // Counter storage; reset puts every entry at weakly-not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_WIDTH'(cnt_init_value(CNT_WIDTH));
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_prediction_gshare.sv
// Gshare / global-history branch predictor with speculative history shift,
// mispredict history restore and a saturating mispredict counter.
module branch_prediction_gshare
    import branch_pred_pkg::*;
#(
    parameter int GHR_WIDTH = 10,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 2,
    parameter int MODE      = MODE_GSHARE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    branch_prediction_gshare_if.slave   bus
);
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_result_q, out_result_d;
    logic [GHR_WIDTH-1:0] out_index_q, out_index_d;
    logic [GHR_WIDTH-1:0] out_history_q, out_history_d;
    logic [15:0]          mis_cnt_q, mis_cnt_d;

    logic [GHR_WIDTH-1:0] pc_bits;
    logic [GHR_WIDTH-1:0] rd_index;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 pred_bit;
    logic                 mispredict;
    logic                 unused_bits;

    assign pc_bits     = bus.predict_pc[GHR_WIDTH+1:2];
    assign rd_index    = (MODE == MODE_GSHARE) ? (ghr_q ^ pc_bits) : ghr_q;
    assign pred_bit    = rd_cnt[CNT_WIDTH-1];
    assign mispredict  = bus.renew_valid && (bus.renew_predict != bus.renew_result);
    assign unused_bits = ^{bus.predict_pc, bus.renew_history[GHR_WIDTH-1]};

    branch_pred_counter_table #(
        .IDX_WIDTH (GHR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (rd_index),
        .rd_cnt   (rd_cnt),
        .wr_en    (bus.renew_valid),
        .wr_index (bus.renew_index),
        .wr_taken (bus.renew_result)
    );

    // Next history, prediction outputs and mispredict count. A mispredict
    // restore overrides the speculative shift, while the prediction issued in
    // the same cycle still reports the pre-restore history.
    always_comb begin
        ghr_d         = ghr_q;
        out_valid_d   = bus.predict_valid;
        out_result_d  = out_result_q;
        out_index_d   = out_index_q;
        out_history_d = out_history_q;
        mis_cnt_d     = mis_cnt_q;
        if (bus.predict_valid) begin
            out_result_d  = pred_bit;
            out_index_d   = rd_index;
            out_history_d = ghr_q;
            ghr_d         = {ghr_q[GHR_WIDTH-2:0], pred_bit};
        end
        if (mispredict) begin
            ghr_d = {bus.renew_history[GHR_WIDTH-2:0], bus.renew_result};
            if (mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    // History and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q         <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 1'b0;
            out_index_q   <= '0;
            out_history_q <= '0;
            mis_cnt_q     <= '0;
        end else begin
            ghr_q         <= ghr_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_index_q   <= out_index_d;
            out_history_q <= out_history_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign bus.predict_out_valid = out_valid_q;
    assign bus.predict_result    = out_result_q;
    assign bus.predict_index     = out_index_q;
    assign bus.predict_history   = out_history_q;
    assign bus.mispredict_count  = mis_cnt_q;

endmodule

// File: tb/tb_branch_prediction_gshare.sv
// Bench for the gshare predictor: a default gshare instance (GHR 10) and a
// global-only instance (GHR 4) driven with the same stimulus. Directed table
// vectors, hand sequences for reset/saturation, then randomized traffic
// checked against a behavioural model.
module tb_branch_prediction_gshare;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_prediction_gshare_if #(.GHR_WIDTH(10), .PC_WIDTH(32)) if_a ();
    branch_prediction_gshare_if #(.GHR_WIDTH(4),  .PC_WIDTH(32)) if_b ();

    branch_prediction_gshare #(.GHR_WIDTH(10), .PC_WIDTH(32), .CNT_WIDTH(2), .MODE(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    branch_prediction_gshare #(.GHR_WIDTH(4), .PC_WIDTH(32), .CNT_WIDTH(2), .MODE(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    int total = 0;
    int bad   = 0;

    // Behavioural model, one slot per DUT.
    int m_gw   [2] = '{10, 4};
    int m_mode [2] = '{1, 0};
    int m_ghr  [2];
    int m_mc   [2];
    int m_cnt  [2][1024];
    int e_ov [2], e_res [2], e_idx [2], e_hist [2];

    typedef struct {
        bit          pv;
        int unsigned pc;
        bit          rv;
        int          ridx;
        int          rhist;
        bit          rpred;
        bit          rres;
        bit          e_ov;
        bit          e_res;
        int          e_idx;
        int          e_hist;
        int          e_mc;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ghr[d] = 0;
            m_mc[d]  = 0;
            e_ov[d] = 0; e_res[d] = 0; e_idx[d] = 0; e_hist[d] = 0;
            for (int i = 0; i < 1024; i++) m_cnt[d][i] = 1;
        end
    endfunction

    // Counter is "taken" when in the upper half of 0..3.
    function automatic void model_step(input int d, input bit pv, input int unsigned pc,
                                       input bit rv, input int ridx, input int rhist,
                                       input bit rpred, input bit rres);
        int depth, idx, new_ghr, ri;
        depth   = 1 << m_gw[d];
        new_ghr = m_ghr[d];
        e_ov[d] = pv;
        if (pv) begin
            if (m_mode[d] == 1) idx = (m_ghr[d] ^ int'(pc / 4)) % depth;
            else                idx = m_ghr[d];
            e_idx[d]  = idx;
            e_hist[d] = m_ghr[d];
            e_res[d]  = (m_cnt[d][idx] >= 2) ? 1 : 0;
            new_ghr   = (m_ghr[d] * 2 + e_res[d]) % depth;
        end
        if (rv) begin
            ri = ridx % depth;
            if (rres) begin
                if (m_cnt[d][ri] < 3) m_cnt[d][ri] = m_cnt[d][ri] + 1;
            end else begin
                if (m_cnt[d][ri] > 0) m_cnt[d][ri] = m_cnt[d][ri] - 1;
            end
            if (rpred != rres) begin
                new_ghr = ((rhist % depth) * 2 + int'(rres)) % depth;
                if (m_mc[d] < 65535) m_mc[d] = m_mc[d] + 1;
            end
        end
        m_ghr[d] = new_ghr;
    endfunction

    task automatic drive(input bit pv, input int unsigned pc, input bit rv, input int ridx,
                         input int rhist, input bit rpred, input bit rres);
        if_a.predict_valid = pv;   if_b.predict_valid = pv;
        if_a.predict_pc    = pc;   if_b.predict_pc    = pc;
        if_a.renew_valid   = rv;   if_b.renew_valid   = rv;
        if_a.renew_index   = 10'(ridx);  if_b.renew_index   = 4'(ridx);
        if_a.renew_history = 10'(rhist); if_b.renew_history = 4'(rhist);
        if_a.renew_predict = rpred; if_b.renew_predict = rpred;
        if_a.renew_result  = rres;  if_b.renew_result  = rres;
        model_step(0, pv, pc, rv, ridx, rhist, rpred, rres);
        model_step(1, pv, pc, rv, ridx, rhist, rpred, rres);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model_a();
        check("a_ov", int'(if_a.predict_out_valid), e_ov[0]);
        check("a_res", int'(if_a.predict_result), e_res[0]);
        check("a_idx", int'(if_a.predict_index), e_idx[0]);
        check("a_hist", int'(if_a.predict_history), e_hist[0]);
        check("a_mc", int'(if_a.mispredict_count), m_mc[0]);
    endtask

    task automatic check_model_b();
        check("b_ov", int'(if_b.predict_out_valid), e_ov[1]);
        check("b_res", int'(if_b.predict_result), e_res[1]);
        check("b_idx", int'(if_b.predict_index), e_idx[1]);
        check("b_hist", int'(if_b.predict_history), e_hist[1]);
        check("b_mc", int'(if_b.mispredict_count), m_mc[1]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        if_a.predict_valid = 0; if_b.predict_valid = 0;
        if_a.renew_valid   = 0; if_b.renew_valid   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov", int'(if_a.predict_out_valid), 0);
        check("rst_res", int'(if_a.predict_result), 0);
        check("rst_idx", int'(if_a.predict_index), 0);
        check("rst_hist", int'(if_a.predict_history), 0);
        check("rst_mc", int'(if_a.mispredict_count), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        //              pv  pc        rv ridx rhist   rp rr  ov res idx     hist    mc
        vecs[0]  = '{1, 32'h100, 0, 0, 0,      0, 0, 1, 0, 'h040, 'h000, 0};
        vecs[1]  = '{0, 32'h0,   1, 5, 0,      1, 1, 0, 0, 'h040, 'h000, 0};
        vecs[2]  = '{0, 32'h0,   1, 5, 0,      1, 1, 0, 0, 'h040, 'h000, 0};
        vecs[3]  = '{0, 32'h0,   1, 5, 0,      1, 1, 0, 0, 'h040, 'h000, 0};
        vecs[4]  = '{1, 32'h14,  0, 0, 0,      0, 0, 1, 1, 'h005, 'h000, 0};
        vecs[5]  = '{0, 32'h0,   0, 0, 0,      0, 0, 0, 1, 'h005, 'h000, 0};
        vecs[6]  = '{0, 32'h0,   1, 7, 'h155,  1, 0, 0, 1, 'h005, 'h000, 1};
        vecs[7]  = '{1, 32'h0,   0, 0, 0,      0, 0, 1, 0, 'h2AA, 'h2AA, 1};
        vecs[8]  = '{1, 32'h574, 1, 9, 0,      1, 1, 1, 0, 'h009, 'h154, 1};
        vecs[9]  = '{1, 32'hA84, 0, 0, 0,      0, 0, 1, 1, 'h009, 'h2A8, 1};
        vecs[10] = '{1, 32'h0,   1, 3, 'h0F0,  0, 1, 1, 0, 'h151, 'h151, 2};
        vecs[11] = '{1, 32'h0,   0, 0, 0,      0, 0, 1, 0, 'h1E1, 'h1E1, 2};

        if_a.predict_pc = '0; if_b.predict_pc = '0;
        if_a.renew_index = '0; if_b.renew_index = '0;
        if_a.renew_history = '0; if_b.renew_history = '0;
        if_a.renew_predict = 0; if_b.renew_predict = 0;
        if_a.renew_result = 0; if_b.renew_result = 0;
        do_reset();

        // Directed table: reset prediction, training, mispredict restore,
        // collision and restore-over-shift priority.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].ridx, vecs[i].rhist,
                  vecs[i].rpred, vecs[i].rres);
            check($sformatf("vec%0d_ov", i), int'(if_a.predict_out_valid), int'(vecs[i].e_ov));
            check($sformatf("vec%0d_res", i), int'(if_a.predict_result), int'(vecs[i].e_res));
            check($sformatf("vec%0d_idx", i), int'(if_a.predict_index), vecs[i].e_idx);
            check($sformatf("vec%0d_hist", i), int'(if_a.predict_history), vecs[i].e_hist);
            check($sformatf("vec%0d_mc", i), int'(if_a.mispredict_count), vecs[i].e_mc);
            check_model_b();
        end

        // Reset while a prediction is in flight.
        drive(1, 32'h14, 0, 0, 0, 0, 0);
        check("inflight_ov", int'(if_a.predict_out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ov", int'(if_a.predict_out_valid), 0);
        check("midrst_mc", int'(if_a.mispredict_count), 0);
        check("midrst_hist", int'(if_a.predict_history), 0);
        model_reset();
        if_a.predict_valid = 0; if_b.predict_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_ov", int'(if_a.predict_out_valid), 0);
        drive(1, 32'h14, 0, 0, 0, 0, 0);
        check("post_rst_res", int'(if_a.predict_result), 0);
        check("post_rst_idx", int'(if_a.predict_index), 5);
        check_model_a();
        check_model_b();

        // Mispredict counter saturation.
        do_reset();
        if_a.predict_valid = 0; if_b.predict_valid = 0;
        if_a.renew_valid = 1;   if_b.renew_valid = 1;
        if_a.renew_index = '0;  if_b.renew_index = '0;
        if_a.renew_predict = 1; if_b.renew_predict = 1;
        if_a.renew_result = 0;  if_b.renew_result = 0;
        @(posedge clk);
        #1;
        check("mc_first", int'(if_a.mispredict_count), 1);
        repeat (65534) @(posedge clk);
        #1;
        check("mc_65535", int'(if_a.mispredict_count), 'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("mc_hold", int'(if_a.mispredict_count), 'hFFFF);
        check("mc_hold_b", int'(if_b.mispredict_count), 'hFFFF);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model_a();
            check_model_b();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_prediction_gshare.md
BRANCH_PREDICTION_GSHARE -- requirements
Module: branch_prediction_gshare

Interface
REQ-001 SHALL have parameter GHR_WIDTH, default 10: global history length and table index width; table depth 2**GHR_WIDTH.
REQ-002 SHALL have parameter PC_WIDTH, default 32: branch PC width; legal only when PC_WIDTH >= GHR_WIDTH+2.
REQ-003 SHALL have parameter CNT_WIDTH, default 2: saturating counter width per entry; legal range 2..4.
REQ-004 SHALL have parameter MODE, default 1: 0 = global-only index, 1 = gshare index.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port predict_valid, input, 1: prediction request this cycle.
REQ-008 SHALL have port predict_pc, input, PC_WIDTH: PC of the branch being predicted.
REQ-009 SHALL have port predict_out_valid, output, 1: registered; predict_result, predict_index and predict_history are valid.
REQ-010 SHALL have port predict_result, output, 1: 1 = taken.
REQ-011 SHALL have port predict_index, output, GHR_WIDTH: table index used; carried by the pipeline back to renew_index.
REQ-012 SHALL have port predict_history, output, GHR_WIDTH: GHR value before the speculative shift; carried back to renew_history.
REQ-013 SHALL have port renew_valid, input, 1: branch resolved this cycle.
REQ-014 SHALL have port renew_index, input, GHR_WIDTH: index returned from the prediction.
REQ-015 SHALL have port renew_history, input, GHR_WIDTH: history snapshot returned from the prediction.
REQ-016 SHALL have port renew_predict, input, 1: prediction originally made.
REQ-017 SHALL have port renew_result, input, 1: actual outcome, 1 = taken.
REQ-018 SHALL have port mispredict_count, output, 16: saturating count of mispredictions.

Function
REQ-019 SHALL compute index = GHR xor predict_pc[GHR_WIDTH+1:2] when MODE=1, and index = GHR when MODE=0.
REQ-020 SHALL register outputs one cycle after predict_valid (latency 1): predict_out_valid=1, predict_result=MSB of counter[index], predict_index=index, predict_history=current GHR.
REQ-021 SHALL drive predict_out_valid=0 in any cycle following one without predict_valid; the other predict outputs hold their last values.
REQ-022 SHALL shift GHR speculatively on predict_valid: GHR <= {GHR[GHR_WIDTH-2:0], predicted bit}.
REQ-023 SHALL update counter[renew_index] on renew_valid: increment when renew_result=1, decrement when 0, saturating at 2**CNT_WIDTH-1 and 0.
REQ-024 SHALL, on renew_valid with renew_predict != renew_result, restore GHR <= {renew_history[GHR_WIDTH-2:0], renew_result} and increment mispredict_count, saturating at 0xFFFF.
REQ-025 SHALL leave GHR unaffected by a renew whose prediction was correct.
REQ-026 SHALL let the mispredict restore take priority over a same-cycle speculative shift; that cycle's prediction output is still produced, from the pre-restore GHR.
REQ-027 SHALL resolve a same-cycle predict and renew to the same index read-before-write: the prediction uses the old counter value.
REQ-028 SHALL update only the addressed entry per renew; all other entries hold.

Reset
REQ-029 SHALL, while rst_n=0, clear GHR, predict_out_valid, predict_result, predict_index, predict_history and mispredict_count to 0.
REQ-030 SHALL initialise every counter to weakly-not-taken, 2**(CNT_WIDTH-1)-1 (01 for CNT_WIDTH=2).
REQ-031 SHALL abort any in-flight prediction output on reset mid-operation; predict_out_valid=0 in the first cycle after release.

Structure
REQ-032 SHALL place the MODE encodings (MODE_GLOBAL=0, MODE_GSHARE=1) and the counter-init and saturate helper functions in shared package branch_pred_pkg.
REQ-033 SHALL implement the table as one sub-module branch_pred_counter_table: one read port, one saturating-update write port, read-before-write behaviour.

Verification
REQ-034 SHALL cover reset: after release, predict at pc=0x100 -> next cycle predict_out_valid=1, predict_result=0, predict_history=0, predict_index=0x040 (MODE=1).
REQ-035 SHALL cover training: 3 renews taken on index 5 -> counter 01->10->11->11 (saturates); the next prediction on index 5 returns 1.
REQ-036 SHALL cover mispredict recovery: renew_history=0x155, renew_predict=1, renew_result=0 -> GHR=0x2AA, mispredict_count +1.
REQ-037 SHALL cover the same-cycle collision: predict and renew on the same index, counter 01, renew taken -> prediction 0 this cycle, 1 on the next predict.
REQ-038 SHALL cover saturation of mispredict_count: 65536 mispredicts -> holds 0xFFFF.
REQ-039 SHALL cover MODE=0 with GHR_WIDTH=4: index equals GHR regardless of predict_pc, 16-entry table.
